// File: rtl/regfile_wb_sched.sv
// Write-back scheduler for the register file: round-robin grant of NSRC sources onto the single
// write port, plus a pending-write scoreboard that decode uses for RAW/WAW stalls.
module regfile_wb_sched #(
   parameter int SIZE = 32,
   parameter int NSRC = 3
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [NSRC-1:0]      src_valid,
   output logic [NSRC-1:0]      src_ready,
   input  logic [5*NSRC-1:0]    src_reg,
   input  logic [SIZE*NSRC-1:0] src_data,
   output logic                 regWrite,
   output logic [4:0]           writeReg,
   output logic [SIZE-1:0]      writeData,
   input  logic                 issue_valid,
   input  logic [4:0]           issue_reg,
   output logic                 issue_ready,
   input  logic [4:0]           rs_addr,
   input  logic [4:0]           rt_addr,
   output logic                 rs_busy,
   output logic                 rt_busy,
   output logic [31:0]          pending,
   output logic                 orphan_err
);
   localparam int IW = (NSRC > 1) ? $clog2(NSRC) : 1;

   logic [NSRC-1:0][4:0]      reg_a;
   logic [NSRC-1:0][SIZE-1:0] data_a;
   logic [IW-1:0]             last;
   logic [IW-1:0]             gnt;
   logic                      found;
   logic                      hs;
   logic [4:0]                sel_reg;
   logic [SIZE-1:0]           sel_data;
   logic [31:0]               pend_nxt;

   assign reg_a  = src_reg;
   assign data_a = src_data;

   // Search starts one past the last winner so every valid source is served within NSRC grants.
   always_comb begin
      found     = 1'b0;
      gnt       = '0;
      src_ready = '0;
      for (int k = 1; k <= NSRC; k++) begin
         if (!found && src_valid[IW'((int'(last) + k) % NSRC)]) begin
            found = 1'b1;
            gnt   = IW'((int'(last) + k) % NSRC);
         end
      end
      if (found && rst_n) src_ready[gnt] = 1'b1;
   end

   assign hs       = |(src_valid & src_ready);
   assign sel_reg  = reg_a[gnt];
   assign sel_data = data_a[gnt];

   assign issue_ready = ~pending[issue_reg] | (issue_reg == 5'd0);
   assign rs_busy     = pending[rs_addr];
   assign rt_busy     = pending[rt_addr];

   // Clear happens on the edge the register file commits; a set on another register coexists.
   always_comb begin
      pend_nxt = pending;
      if (regWrite) pend_nxt[writeReg] = 1'b0;
      if (issue_valid && issue_ready && issue_reg != 5'd0) pend_nxt[issue_reg] = 1'b1;
      pend_nxt[0] = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         regWrite   <= 1'b0;
         writeReg   <= '0;
         writeData  <= '0;
         pending    <= '0;
         orphan_err <= 1'b0;
         last       <= IW'(NSRC - 1);
      end else begin
         pending <= pend_nxt;
         if (hs) begin
            writeReg  <= sel_reg;
            writeData <= sel_data;
            regWrite  <= (sel_reg != 5'd0);
            last      <= gnt;
            if (sel_reg != 5'd0 && !pending[sel_reg]) orphan_err <= 1'b1;
         end else begin
            regWrite <= 1'b0;
         end
      end
   end
endmodule
